// File: rtl/fmul_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// fmul_pipe_ctrl_if
//   Handshake and bus bundle between the FP multiplier issue controller and
//   its surroundings: two requesters, the mul-stage operand mux, the three
//   pipeline register enables and the result handshake.
//
//   master : requesters, consumer and pipeline owner (drives requests,
//            flush and res_ready)
//   slave  : fmul_pipe_ctrl (drives readys, operands, enables, result)
// -----------------------------------------------------------------------------
interface fmul_pipe_ctrl_if #(
   parameter int TAG_W = 4
);
   logic             flush;

   logic             req0_valid;
   logic [31:0]      req0_a;
   logic [31:0]      req0_b;
   logic [1:0]       req0_rm;
   logic [TAG_W-1:0] req0_tag;
   logic             req0_ready;

   logic             req1_valid;
   logic [31:0]      req1_a;
   logic [31:0]      req1_b;
   logic [1:0]       req1_rm;
   logic [TAG_W-1:0] req1_tag;
   logic             req1_ready;

   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [1:0]       op_rm;
   logic             en_s1;
   logic             en_s2;
   logic             en_s3;

   logic             res_valid;
   logic             res_src;
   logic [TAG_W-1:0] res_tag;
   logic             res_ready;

   logic             busy;
   logic [1:0]       inflight;

   modport master (
      output flush,
      output req0_valid, req0_a, req0_b, req0_rm, req0_tag,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_rm, req1_tag,
      input  req1_ready,
      input  op_a, op_b, op_rm, en_s1, en_s2, en_s3,
      input  res_valid, res_src, res_tag,
      output res_ready,
      input  busy, inflight
   );

   modport slave (
      input  flush,
      input  req0_valid, req0_a, req0_b, req0_rm, req0_tag,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_rm, req1_tag,
      output req1_ready,
      output op_a, op_b, op_rm, en_s1, en_s2, en_s3,
      output res_valid, res_src, res_tag,
      input  res_ready,
      output busy, inflight
   );
endinterface

// File: rtl/fmul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// fmul_pipe_ctrl
//   Issue / sequencing controller for a 3-stage pipelined FP multiplier
//   (mul -> add -> normalize/round). Round-robin arbitrates two requesters,
//   muxes the granted operands into the mul stage, drives the three pipeline
//   register enables, and carries source ID + tag alongside the data to a
//   valid/ready result port with backpressure.
//
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : fmul_pipe_ctrl_if.slave (requests, operands, enables,
//                 result handshake, flush, busy/inflight status)
//     perf_issue, perf_stall : saturating counters, present only when
//                 FMUL_PIPE_CTRL_PERF_EN is defined
//
//   Optional feature macro: FMUL_PIPE_CTRL_PERF_EN
// -----------------------------------------------------------------------------
module fmul_pipe_ctrl #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   fmul_pipe_ctrl_if.slave  bus
`ifdef FMUL_PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_issue,
   output logic [CNT_W-1:0] perf_stall
`endif
);

   typedef struct packed {
      logic             src;
      logic [TAG_W-1:0] tag;
   } meta_t;

   // stage valid bits, index = stage number
   logic  [3:1] vld_q, vld_d;
   meta_t [3:1] meta_q, meta_d;
   logic        rr_q, rr_d;

   logic adv1, adv2, adv3;
   logic gnt1;
   logic acc0, acc1, accept;

   // A stage may load whenever it is empty or its content can move on, so
   // bubbles collapse even while the output is stalled.
   always_comb begin
      adv3 = ~vld_q[3] | bus.res_ready;
      adv2 = ~vld_q[2] | adv3;
      adv1 = ~vld_q[1] | adv2;
   end

   // Grant: a lone requester wins; on contention rr decides. With no
   // request the mux idles on req0.
   always_comb begin
      gnt1 = bus.req1_valid & (~bus.req0_valid | rr_q);
   end

   // rst gating keeps readys low for the whole reset window, not just after
   // the valid bits clear.
   always_comb begin
      acc0   = ~gnt1 & bus.req0_valid & adv1 & ~bus.flush & ~rst;
      acc1   =  gnt1 & bus.req1_valid & adv1 & ~bus.flush & ~rst;
      accept = acc0 | acc1;
   end

   always_comb begin
      bus.op_a       = gnt1 ? bus.req1_a  : bus.req0_a;
      bus.op_b       = gnt1 ? bus.req1_b  : bus.req0_b;
      bus.op_rm      = gnt1 ? bus.req1_rm : bus.req0_rm;
      bus.en_s1      = adv1;
      bus.en_s2      = adv2;
      bus.en_s3      = adv3;
      bus.req0_ready = acc0;
      bus.req1_ready = acc1;
      // flush drops the output entry rather than delivering it
      bus.res_valid  = vld_q[3] & ~bus.flush;
      bus.res_src    = meta_q[3].src;
      bus.res_tag    = meta_q[3].tag;
      bus.busy       = |vld_q;
      bus.inflight   = {1'b0, vld_q[1]} + {1'b0, vld_q[2]} + {1'b0, vld_q[3]};
   end

   always_comb begin
      vld_d  = vld_q;
      meta_d = meta_q;
      rr_d   = rr_q;
      if (adv3) begin
         vld_d[3]  = vld_q[2];
         meta_d[3] = meta_q[2];
      end
      if (adv2) begin
         vld_d[2]  = vld_q[1];
         meta_d[2] = meta_q[1];
      end
      if (adv1) begin
         vld_d[1] = accept;
         if (accept) begin
            meta_d[1].src = gnt1;
            meta_d[1].tag = gnt1 ? bus.req1_tag : bus.req0_tag;
         end
      end
      // favour the other requester after every accept
      if (accept) rr_d = ~gnt1;
      // metadata of killed entries is left to shift; it is never observed
      if (bus.flush) vld_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         meta_q <= '0;
         rr_q   <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         meta_q <= meta_d;
         rr_q   <= rr_d;
      end
   end

`ifdef FMUL_PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_issue_q, perf_issue_d;
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

   // Saturating; flush does not touch them.
   always_comb begin
      perf_issue_d = perf_issue_q;
      perf_stall_d = perf_stall_q;
      if (accept && ~&perf_issue_q)
         perf_issue_d = perf_issue_q + 1'b1;
      if (vld_q[3] && ~bus.res_ready && ~&perf_stall_q)
         perf_stall_d = perf_stall_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_issue_q <= perf_issue_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_issue = perf_issue_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule
